device_c_assembler: RTL

DEVICE_C_ASSEMBLER -- requirements
Module: device_c_assembler

---
 rtl/device_c_assembler.sv | 80 ++++++++
 1 files changed

// File: rtl/device_c_assembler.sv
// Four-word frame assembler: captures 16-bit words under a readyB/acceptedC handshake,
// packs them MSB-first into a 64-bit frame with a wrap-around 16-bit sum.
module device_c_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        readyB,
    input  logic [15:0] in_C,
    output logic        acceptedC,
    input  logic        ackC,
    output logic        validC,
    output logic [63:0] out_C,
    output logic [15:0] sum_C,
    output logic [1:0]  word_cnt
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCapture = 2'd1;
    localparam logic [1:0] StWaitLow = 2'd2;
    localparam logic [1:0] StFull    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] frame_q, frame_d;
    logic [15:0] sum_q, sum_d;
    logic [5:0]  slot_lsb;

    // Slot 0 lands in the top 16 bits, slot 3 in the bottom.
    assign slot_lsb = {~cnt_q, 4'b0000};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        sum_d   = sum_q;
        case (state_q)
            StIdle: begin
                if (readyB) begin
                    state_d                = StCapture;
                    frame_d[slot_lsb +: 16] = in_C;
                    sum_d                  = sum_q + in_C;
                end
            end
            StCapture: state_d = StWaitLow;
            StWaitLow: begin
                if (!readyB) begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = (cnt_q == 2'd3) ? StFull : StIdle;
                end
            end
            StFull: begin
                if (ackC) begin
                    state_d = StIdle;
                    sum_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            frame_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            sum_q   <= sum_d;
        end
    end

    assign acceptedC = (state_q == StCapture);
    assign validC    = (state_q == StFull);
    assign out_C     = frame_q;
    assign sum_C     = sum_q;
    assign word_cnt  = cnt_q;

endmodule
